uart_rx_dec: RTL
================

Name: uart_rx_dec

Overview:
- Parametrised UART receive front end.
  - Replaces the fixed 9600-baud receiver plus ASCII-to-digit path.
  - Configurable clock/baud, data width and oversampling; runtime parity mode.
- Adds the following, then feeds the 7-segment decoder directly:
  - 16x oversampled majority-vote sampling.
  - False-start rejection.
  - Parity, framing and overrun detection.
  - A valid/ack handshake.
  - A registered ASCII-digit decode.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
DATA_BITS, 8, data bits per frame (5..8), LSB first
OVERSAMPLE, 16, ticks per bit (even, >=8)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none; captured at start-bit detection
rx_ack  input  1  consumer acknowledge; clears rx_valid and overrun
rx_data  output  DATA_BITS  last received data word
rx_valid  output  1  high from frame completion until rx_ack
parity_err  output  1  parity status of last frame
frame_err  output  1  stop-bit status of last frame
overrun  output  1  sticky; a frame completed while rx_valid was high
busy  output  1  high in any state other than IDLE
dec_out  output  4  rx_data minus 0x30 when rx_data is ASCII '0'..'9', else 4'hF
is_digit  output  1  rx_data in 0x30..0x39

Behaviour:
- Reset:
  - rx passes through a 2-FF synchroniser; both flops reset to 1.
  - Async reset forces all state to IDLE and clears all counters.
  - Outputs at reset: rx_data=0, rx_valid/parity_err/frame_err/overrun/busy/is_digit=0, dec_out=4'hF.
  - Reset mid-frame abandons the frame with no output.
- Tick generator:
  - TICK_DIV = CLK_FREQ/(BAUD*OVERSAMPLE), truncated (325 at defaults).
  - Free-running counter; 1-cycle tick when it reaches TICK_DIV-1, then wraps to 0.
- Sampling:
  - os_cnt counts ticks 0..OVERSAMPLE-1 within a bit.
  - Samples are taken at ticks M-1, M, M+1, where M=OVERSAMPLE/2.
  - Bit value is the 2-of-3 majority, decided at tick M+1.
- FSM:
  - IDLE: on a tick with synchronised rx=0 -> START, os_cnt=0, capture parity_mode.
  - START: at M+1, majority=1 -> IDLE (false start, nothing reported). Otherwise -> DATA at os_cnt wrap.
  - DATA: shift DATA_BITS bits, LSB first. After the last bit -> PARITY if mode is even/odd, else -> STOP.
  - PARITY: even mode requires even ones-count over data+parity bit; odd mode requires odd. Mismatch sets the frame's parity error.
  - STOP: at M+1 (not end of bit), complete the frame. Next state is IDLE if stop=1, else BREAK.
  - BREAK: wait for a tick with synchronised rx=1 -> IDLE; a held-low line never restarts reception.
- Frame completion (clock after the stop-bit M+1 tick):
  - Register rx_data, parity_err, frame_err (=~stop), dec_out and is_digit together.
  - Set rx_valid=1. Data is delivered even on error.
  - Error flags reflect only the latest frame.
- Handshake:
  - rx_ack=1 clears rx_valid and overrun next clock.
  - Completion while rx_valid=1: overwrite rx_data, set overrun=1.
  - Completion and rx_ack in the same cycle: completion wins, rx_valid stays 1, overrun unchanged.
- Latency: about 1.5 bit times plus 3 clocks from the start-bit edge to the first data-bit decision (including the synchroniser); rx_valid rises one clock after the stop decision tick.
- DATA_BITS<8: dec_out/is_digit compare the zero-extended word.

Test Plan:
1. Defaults, parity_mode=00, send 8N1 0x41 at 5200 clk/bit -> rx_data=0x41, rx_valid=1, is_digit=0, dec_out=F, parity_err=frame_err=0.
2. parity_mode=01, send 0x37 with parity bit 1 -> dec_out=7, is_digit=1, parity_err=0. Repeat with parity_mode=10 -> parity_err=1, rx_data=0x37.
3. rx low for 975 clk (3 ticks) then high -> no rx_valid, busy returns to 0 by tick M+1, FSM back in IDLE.
4. Send 0x35 with stop bit 0, hold rx low 3 bit times -> frame_err=1, rx_valid=1, no further frame. Release rx, send 0x36 -> dec_out=6, frame_err=0.
5. Back-to-back 0x31 then 0x32 with no rx_ack -> rx_data=0x32, overrun=1. Pulse rx_ack -> rx_valid=0, overrun=0 next clock.
6. Drop rst_n during data bit 3 of 0xAA -> all outputs at reset values immediately. Release, send 0x55 -> rx_data=0x55, no errors.

Source files
------------

// File: rtl/uart_rx_dec_if.sv
// Receiver-side bundle for uart_rx_dec: serial line and parity mode in,
// decoded word, status flags and the valid/ack handshake out.
interface uart_rx_dec_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 rx;
  logic [1:0]           parity_mode;
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
  logic [3:0]           dec_out;
  logic                 is_digit;

  modport master (
    output rx, parity_mode, rx_ack,
    input  rx_data, rx_valid, parity_err, frame_err, overrun, busy, dec_out, is_digit
  );

  modport slave (
    input  rx, parity_mode, rx_ack,
    output rx_data, rx_valid, parity_err, frame_err, overrun, busy, dec_out, is_digit
  );
endinterface

// File: rtl/uart_rx_dec.sv
// Oversampled UART receiver with majority-vote sampling, parity/framing/overrun
// detection, a valid/ack handshake and a registered ASCII-digit decode.
module uart_rx_dec #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_dec_if.slave bus
);

  localparam int unsigned TickDiv = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned TickW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned OsW     = $clog2(OVERSAMPLE);
  localparam int unsigned BitW    = $clog2(DATA_BITS + 1);

  localparam logic [TickW-1:0] TickLast = TickW'(TickDiv - 1);
  localparam logic [OsW-1:0]   OsLast   = OsW'(OVERSAMPLE - 1);
  localparam logic [OsW-1:0]   SampA    = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [OsW-1:0]   SampB    = OsW'(OVERSAMPLE / 2);
  localparam logic [OsW-1:0]   SampC    = OsW'(OVERSAMPLE / 2 + 1);
  localparam logic [BitW-1:0]  BitsLast = BitW'(DATA_BITS);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e               state_q;
  logic                 rx_meta_q, rx_sync_q;
  logic [TickW-1:0]     tick_cnt_q;
  logic [OsW-1:0]       os_cnt_q;
  logic [1:0]           samp_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [1:0]           mode_q;
  logic                 par_bad_q;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, parity_err_q, frame_err_q, overrun_q, busy_q;
  logic [3:0]           dec_out_q;
  logic                 is_digit_q;

  logic       tick, decide, os_wrap, maj, par_bad, digit;
  logic [7:0] word8;
  logic [3:0] dec_val;

  // Two-flop synchroniser, idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick_cnt_q == TickLast) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TickW'(1);
    end
  end

  always_comb begin
    tick    = (tick_cnt_q == TickLast);
    decide  = tick && (os_cnt_q == SampC);
    os_wrap = tick && (os_cnt_q == OsLast);
    // Third sample is the live synchronised value at tick M+1.
    maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);
    par_bad = (mode_q == 2'b01) ? (^{shift_q, maj}) : ~(^{shift_q, maj});
    word8   = '0;
    word8[DATA_BITS-1:0] = shift_q;
    digit   = (word8 >= 8'h30) && (word8 <= 8'h39);
    // Low nibble of '0'..'9' already equals the digit value.
    dec_val = digit ? word8[3:0] : 4'hF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      os_cnt_q     <= '0;
      samp_q       <= 2'b11;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      mode_q       <= 2'b00;
      par_bad_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      dec_out_q    <= 4'hF;
      is_digit_q   <= 1'b0;
    end else begin
      if (bus.rx_ack) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end

      if (tick && (state_q inside {StStart, StData, StParity, StStop})) begin
        os_cnt_q <= (os_cnt_q == OsLast) ? '0 : os_cnt_q + OsW'(1);
        if (os_cnt_q == SampA) samp_q[0] <= rx_sync_q;
        if (os_cnt_q == SampB) samp_q[1] <= rx_sync_q;
      end

      if (tick) begin
        unique case (state_q)
          StIdle: begin
            if (!rx_sync_q) begin
              state_q   <= StStart;
              busy_q    <= 1'b1;
              os_cnt_q  <= '0;
              bit_cnt_q <= '0;
              par_bad_q <= 1'b0;
              mode_q    <= bus.parity_mode;
            end
          end
          StStart: begin
            if (decide && maj) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else if (os_wrap) begin
              state_q <= StData;
            end
          end
          StData: begin
            if (decide) begin
              shift_q   <= {maj, shift_q[DATA_BITS-1:1]};
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
            if (os_wrap && (bit_cnt_q == BitsLast)) begin
              state_q <= (mode_q == 2'b01 || mode_q == 2'b10) ? StParity : StStop;
            end
          end
          StParity: begin
            if (decide)  par_bad_q <= par_bad;
            if (os_wrap) state_q   <= StStop;
          end
          StStop: begin
            if (decide) begin
              rx_data_q    <= shift_q;
              parity_err_q <= par_bad_q;
              frame_err_q  <= ~maj;
              dec_out_q    <= dec_val;
              is_digit_q   <= digit;
              rx_valid_q   <= 1'b1;
              // A simultaneous ack leaves overrun exactly as it was.
              overrun_q    <= bus.rx_ack ? overrun_q : (overrun_q | rx_valid_q);
              state_q      <= maj ? StIdle : StBreak;
              busy_q       <= ~maj;
            end
          end
          StBreak: begin
            if (rx_sync_q) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = busy_q;
  assign bus.dec_out    = dec_out_q;
  assign bus.is_digit   = is_digit_q;

endmodule
